register_file_writeback: RTL and testbench

- Destination end of the datapath write-back path: receives the value chosen by the write-back selector (ALU result vs. memory read data) and commits it to the 32 x 32-bit integer register file.
- Serves the two decode-stage operand reads, with write-to-read bypass.
- Holds a pending-write scoreboard so decode can stall on operands whose producer has not yet written back.

---
 rtl/register_file_writeback.sv | 65 ++++++
 tb/tb_register_file_writeback.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/register_file_writeback.sv
// rtl/register_file_writeback.sv - integer register file with write-back commit, read bypass and pending-write scoreboard
module register_file_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_reg,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  stall
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0]  pending;
  logic                  hit1;
  logic                  hit2;
  logic                  do_write;
  logic                  do_issue;

  assign do_write = write_enable && (write_reg != '0);
  assign do_issue = issue_valid && (issue_reg != '0);

  // The issue update comes last so a new producer overrides a completing one on the same index.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      if (do_write) begin
        regs[write_reg]    <= write_data;
        pending[write_reg] <= 1'b0;
      end
      if (do_issue) begin
        pending[issue_reg] <= 1'b1;
      end
    end
  end

  assign hit1 = write_enable && (write_reg == read_reg1);
  assign hit2 = write_enable && (write_reg == read_reg2);

  // Outputs are forced quiet while reset is held, regardless of bypass.
  assign read_data1 = (!reset || read_reg1 == '0) ? '0 : (hit1 ? write_data : regs[read_reg1]);
  assign read_data2 = (!reset || read_reg2 == '0) ? '0 : (hit2 ? write_data : regs[read_reg2]);

  assign busy1 = reset && (read_reg1 != '0) && pending[read_reg1] && !hit1;
  assign busy2 = reset && (read_reg2 != '0) && pending[read_reg2] && !hit2;

  assign stall = (use_rs1 && busy1) || (use_rs2 && busy2);

endmodule

// File: tb/tb_register_file_writeback.sv
// tb/tb_register_file_writeback.sv - scoreboard bench for register_file_writeback
module tb_register_file_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic        use_rs1;
  logic        use_rs2;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        busy1;
  logic        busy2;
  logic        stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        st;
  } exp_t;

  exp_t exp_q[$];

  register_file_writeback dut (
    .clock       (clock),
    .reset       (reset),
    .write_enable(write_enable),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .use_rs1     (use_rs1),
    .use_rs2     (use_rs2),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .busy1       (busy1),
    .busy2       (busy2),
    .stall       (stall)
  );

  always #5 clock = ~clock;

  task automatic check32(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  // Monitor: the design is combinational on the read side, so each cycle's
  // outputs are presented mid-cycle and compared on the falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check32(e.name, "read_data1", read_data1, e.rd1);
      check32(e.name, "read_data2", read_data2, e.rd2);
      check32(e.name, "busy1", {31'd0, busy1}, {31'd0, e.b1});
      check32(e.name, "busy2", {31'd0, busy2}, {31'd0, e.b2});
      check32(e.name, "stall", {31'd0, stall}, {31'd0, e.st});
    end
  end

  task automatic cyc(input string name, input logic rst, input logic we, input logic [4:0] wr,
                     input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic iv, input logic [4:0] ir,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input logic eb1, input logic eb2, input logic est);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; write_enable = we; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2; use_rs1 = u1; use_rs2 = u2;
    issue_valid = iv; issue_reg = ir;
    e.name = name; e.rd1 = e1; e.rd2 = e2; e.b1 = eb1; e.b2 = eb2; e.st = est;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; write_enable = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    issue_valid = 1'b0; issue_reg = '0;

    //   name          rst we wr  wd            r1 r2 u1 u2 iv ir  rd1           rd2           b1 b2 st
    cyc("rst_hold0",   0, 1, 5, 32'hDEADBEEF,  5, 5, 1, 1, 1, 5,  32'h0,        32'h0,        0, 0, 0);
    cyc("rst_hold1",   0, 1, 5, 32'hDEADBEEF,  5, 0, 1, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    cyc("rst_after",   1, 0, 0, 32'h0,         5, 5, 1, 1, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    cyc("wr_x7",       1, 1, 7, 32'h12345678,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    cyc("rd_x7",       1, 0, 0, 32'h0,         7, 7, 1, 1, 0, 0,  32'h12345678, 32'h12345678, 0, 0, 0);
    cyc("wr_x0",       1, 1, 0, 32'hFFFFFFFF,  0, 0, 1, 1, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    cyc("rd_x0",       1, 0, 0, 32'h0,         0, 7, 1, 1, 0, 0,  32'h0,        32'h12345678, 0, 0, 0);
    cyc("bypass_x3",   1, 1, 3, 32'hA5A5A5A5,  7, 3, 1, 1, 0, 0,  32'h12345678, 32'hA5A5A5A5, 0, 0, 0);
    cyc("rd_x3",       1, 0, 0, 32'h0,         3, 3, 1, 1, 0, 0,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0);
    cyc("issue_x9",    1, 0, 0, 32'h0,         9, 0, 1, 0, 1, 9,  32'h0,        32'h0,        0, 0, 0);
    cyc("stall_x9",    1, 0, 0, 32'h0,         9, 0, 1, 0, 0, 0,  32'h0,        32'h0,        1, 0, 1);
    cyc("nouse_x9",    1, 0, 0, 32'h0,         9, 0, 0, 0, 0, 0,  32'h0,        32'h0,        1, 0, 0);
    cyc("stall2_x9",   1, 0, 0, 32'h0,         0, 9, 0, 1, 0, 0,  32'h0,        32'h0,        0, 1, 1);
    cyc("wb_x9",       1, 1, 9, 32'h00000099,  9, 0, 1, 0, 0, 0,  32'h00000099, 32'h0,        0, 0, 0);
    cyc("clr_x9",      1, 0, 0, 32'h0,         9, 9, 1, 1, 0, 0,  32'h00000099, 32'h00000099, 0, 0, 0);
    cyc("issue_x4",    1, 0, 0, 32'h0,         0, 0, 0, 0, 1, 4,  32'h0,        32'h0,        0, 0, 0);
    cyc("pend_x4",     1, 0, 0, 32'h0,         4, 0, 1, 0, 0, 0,  32'h0,        32'h0,        1, 0, 1);
    cyc("setclr_x4",   1, 1, 4, 32'h00000044,  4, 0, 1, 0, 1, 4,  32'h00000044, 32'h0,        0, 0, 0);
    cyc("setwins_x4",  1, 0, 0, 32'h0,         4, 0, 1, 0, 0, 0,  32'h00000044, 32'h0,        1, 0, 1);
    cyc("clr4_set6",   1, 1, 4, 32'h00000055,  4, 6, 1, 1, 1, 6,  32'h00000055, 32'h0,        0, 0, 0);
    cyc("x4clr_x6bsy", 1, 0, 0, 32'h0,         4, 6, 1, 1, 0, 0,  32'h00000055, 32'h0,        0, 1, 1);
    cyc("wr_x2",       1, 1, 2, 32'h00000022,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    cyc("wr_x8",       1, 1, 8, 32'h00000088,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    cyc("issue_x2",    1, 0, 0, 32'h0,         0, 0, 0, 0, 1, 2,  32'h0,        32'h0,        0, 0, 0);
    cyc("issue_x8",    1, 0, 0, 32'h0,         2, 8, 1, 1, 1, 8,  32'h00000022, 32'h00000088, 1, 0, 1);
    cyc("pend_x2x8",   1, 0, 0, 32'h0,         2, 8, 1, 1, 0, 0,  32'h00000022, 32'h00000088, 1, 1, 1);
    cyc("mid_reset",   0, 0, 0, 32'h0,         2, 8, 1, 1, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    cyc("post_reset",  1, 0, 0, 32'h0,         2, 8, 1, 1, 0, 0,  32'h0,        32'h0,        0, 0, 0);
    cyc("post_rst_x4", 1, 0, 0, 32'h0,         4, 6, 1, 1, 0, 0,  32'h0,        32'h0,        0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clock);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
